// File: rtl/fpu_pkg.sv
// Shared FPU types: compare/min-max opcodes, the canonical NaN and
// operand classification for IEEE-754 single precision.
package fpu_pkg;

  typedef enum logic [2:0] {
    FEQ  = 3'd0,
    FLT  = 3'd1,
    FLE  = 3'd2,
    FMIN = 3'd3,
    FMAX = 3'd4
  } fcmp_op_t;

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  typedef struct packed {
    logic nan;
    logic snan;
    logic zero;
  } fp_class_t;

  // Takes the magnitude only; the sign does not change the class.
  function automatic fp_class_t fp_classify(input logic [30:0] mag);
    fp_class_t c;
    c.nan  = (mag[30:23] == 8'hFF) && (mag[22:0] != 23'd0);
    c.snan = c.nan && !mag[22];
    c.zero = (mag == 31'd0);
    return c;
  endfunction

endpackage

// File: rtl/fcmp_pipe_if.sv
// Issue-side and writeback-side handshake bundle of the FP compare stage.
// master = issuer/writeback, slave = the compare stage.
interface fcmp_pipe_if #(
  parameter int TAG_W = 5
);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [31:0]      in_x;
  logic [31:0]      in_y;
  logic [TAG_W-1:0] in_rd;

  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_rd;
  logic             out_to_int;
  logic             out_nv;

  modport master (
    output in_valid, in_op, in_x, in_y, in_rd, out_ready,
    input  in_ready, out_valid, out_data, out_rd, out_to_int, out_nv
  );

  modport slave (
    input  in_valid, in_op, in_x, in_y, in_rd, out_ready,
    output in_ready, out_valid, out_data, out_rd, out_to_int, out_nv
  );

endinterface

// File: rtl/fcmp_core.sv
// Ordered less-than / equal of two single-precision operands.
// Both results are forced low when either operand is a NaN.
module fcmp_core (
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        x_nan,
  input  logic        y_nan,
  input  logic        x_zero,
  input  logic        y_zero,
  output logic        lt,
  output logic        eq
);

  logic both_zero;

  assign both_zero = x_zero && y_zero;

  // Sign-magnitude ordering: negative magnitudes compare in reverse.
  always_comb begin
    lt = 1'b0;
    eq = 1'b0;
    if (!(x_nan || y_nan)) begin
      eq = (x == y) || both_zero;
      if (x[31] != y[31]) begin
        lt = x[31] && !both_zero;
      end else if (!x[31]) begin
        lt = x[30:0] < y[30:0];
      end else begin
        lt = x[30:0] > y[30:0];
      end
    end
  end

endmodule

// File: rtl/fcmp_pipe.sv
// Two-stage FEQ/FLT/FLE/FMIN/FMAX execute stage with valid/ready on both
// sides, flush of all in-flight ops, and tagged results for writeback.
module fcmp_pipe
  import fpu_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        flush,
  fcmp_pipe_if.slave  bus
);

  logic             s1_v_q,    s1_v_d;
  fcmp_op_t         s1_op_q,   s1_op_d;
  logic [31:0]      s1_x_q,    s1_x_d;
  logic [31:0]      s1_y_q,    s1_y_d;
  logic [TAG_W-1:0] s1_rd_q,   s1_rd_d;
  fp_class_t        s1_cx_q,   s1_cx_d;
  fp_class_t        s1_cy_q,   s1_cy_d;
  logic             s1_lt_q,   s1_lt_d;
  logic             s1_eq_q,   s1_eq_d;

  logic             s2_v_q,      s2_v_d;
  logic [31:0]      s2_data_q,   s2_data_d;
  logic [TAG_W-1:0] s2_rd_q,     s2_rd_d;
  logic             s2_to_int_q, s2_to_int_d;
  logic             s2_nv_q,     s2_nv_d;

  logic      s1_adv, s2_adv, accept;
  fp_class_t in_cx, in_cy;
  logic      in_lt, in_eq;

  logic [31:0] res_data;
  logic        res_to_int, res_nv;
  logic        any_nan, any_snan;

  assign s2_adv = !s2_v_q || bus.out_ready;
  assign s1_adv = !s1_v_q || s2_adv;
  assign bus.in_ready = s1_adv && !flush;
  assign accept = bus.in_valid && bus.in_ready;

  assign in_cx = fp_classify(bus.in_x[30:0]);
  assign in_cy = fp_classify(bus.in_y[30:0]);

  fcmp_core u_core (
    .x      (bus.in_x),
    .y      (bus.in_y),
    .x_nan  (in_cx.nan),
    .y_nan  (in_cy.nan),
    .x_zero (in_cx.zero),
    .y_zero (in_cy.zero),
    .lt     (in_lt),
    .eq     (in_eq)
  );

  assign any_nan  = s1_cx_q.nan  || s1_cy_q.nan;
  assign any_snan = s1_cx_q.snan || s1_cy_q.snan;

  // Result selection from the classified S1 operands.
  always_comb begin
    res_data   = 32'd0;
    res_to_int = 1'b1;
    res_nv     = 1'b0;
    case (s1_op_q)
      FEQ: begin
        res_data = {31'd0, s1_eq_q};
        res_nv   = any_snan;
      end
      FLT: begin
        res_data = {31'd0, s1_lt_q && !any_nan};
        res_nv   = any_nan;
      end
      FLE: begin
        res_data = {31'd0, (s1_lt_q || s1_eq_q) && !any_nan};
        res_nv   = any_nan;
      end
      FMIN, FMAX: begin
        res_to_int = 1'b0;
        res_nv     = any_snan;
        if (s1_cx_q.nan && s1_cy_q.nan) begin
          res_data = CANON_NAN;
        end else if (s1_cx_q.nan) begin
          res_data = s1_y_q;
        end else if (s1_cy_q.nan) begin
          res_data = s1_x_q;
        end else if (s1_cx_q.zero && s1_cy_q.zero) begin
          // -0 orders below +0 here even though they compare equal.
          if (s1_op_q == FMIN) begin
            res_data = s1_x_q[31] ? s1_x_q : s1_y_q;
          end else begin
            res_data = s1_x_q[31] ? s1_y_q : s1_x_q;
          end
        end else if (s1_op_q == FMIN) begin
          res_data = s1_lt_q ? s1_x_q : s1_y_q;
        end else begin
          res_data = s1_lt_q ? s1_y_q : s1_x_q;
        end
      end
      default: begin
        res_data   = 32'd0;
        res_to_int = 1'b1;
        res_nv     = 1'b0;
      end
    endcase
  end

  // Stage advance and flush; stalled stages keep every field unchanged.
  always_comb begin
    s1_v_d      = s1_v_q;
    s1_op_d     = s1_op_q;
    s1_x_d      = s1_x_q;
    s1_y_d      = s1_y_q;
    s1_rd_d     = s1_rd_q;
    s1_cx_d     = s1_cx_q;
    s1_cy_d     = s1_cy_q;
    s1_lt_d     = s1_lt_q;
    s1_eq_d     = s1_eq_q;
    s2_v_d      = s2_v_q;
    s2_data_d   = s2_data_q;
    s2_rd_d     = s2_rd_q;
    s2_to_int_d = s2_to_int_q;
    s2_nv_d     = s2_nv_q;

    if (s1_adv) begin
      s1_v_d = accept;
      if (accept) begin
        s1_op_d = fcmp_op_t'(bus.in_op);
        s1_x_d  = bus.in_x;
        s1_y_d  = bus.in_y;
        s1_rd_d = bus.in_rd;
        s1_cx_d = in_cx;
        s1_cy_d = in_cy;
        s1_lt_d = in_lt;
        s1_eq_d = in_eq;
      end
    end

    if (s2_adv) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        s2_data_d   = res_data;
        s2_rd_d     = s1_rd_q;
        s2_to_int_d = res_to_int;
        s2_nv_d     = res_nv;
      end
    end

    if (flush) begin
      s1_v_d = 1'b0;
      s2_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_v_q      <= 1'b0;
      s1_op_q     <= FEQ;
      s1_x_q      <= 32'd0;
      s1_y_q      <= 32'd0;
      s1_rd_q     <= '0;
      s1_cx_q     <= '0;
      s1_cy_q     <= '0;
      s1_lt_q     <= 1'b0;
      s1_eq_q     <= 1'b0;
      s2_v_q      <= 1'b0;
      s2_data_q   <= 32'd0;
      s2_rd_q     <= '0;
      s2_to_int_q <= 1'b0;
      s2_nv_q     <= 1'b0;
    end else begin
      s1_v_q      <= s1_v_d;
      s1_op_q     <= s1_op_d;
      s1_x_q      <= s1_x_d;
      s1_y_q      <= s1_y_d;
      s1_rd_q     <= s1_rd_d;
      s1_cx_q     <= s1_cx_d;
      s1_cy_q     <= s1_cy_d;
      s1_lt_q     <= s1_lt_d;
      s1_eq_q     <= s1_eq_d;
      s2_v_q      <= s2_v_d;
      s2_data_q   <= s2_data_d;
      s2_rd_q     <= s2_rd_d;
      s2_to_int_q <= s2_to_int_d;
      s2_nv_q     <= s2_nv_d;
    end
  end

  assign bus.out_valid  = s2_v_q;
  assign bus.out_data   = s2_data_q;
  assign bus.out_rd     = s2_rd_q;
  assign bus.out_to_int = s2_to_int_q;
  assign bus.out_nv     = s2_nv_q;

endmodule

// File: tb/tb_fcmp_pipe.sv
// Directed-vector bench for fcmp_pipe: single-op table plus stall,
// flush and async-reset sequences.
module tb_fcmp_pipe;

  logic clk = 1'b0;
  logic rstn;
  logic flush;

  int passed = 0;
  int total  = 0;

  fcmp_pipe_if #(.TAG_W(5)) bus ();

  fcmp_pipe #(.TAG_W(5)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] data;
    logic        to_int;
    logic        nv;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      passed++;
    end
  endtask

  // Drive at a negedge, expect out_valid exactly two edges later.
  task automatic run_vector(input vec_t v, input logic [4:0] rd, input string tag);
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_op     = v.op;
    bus.in_x      = v.x;
    bus.in_y      = v.y;
    bus.in_rd     = rd;
    #1;
    check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    check({tag, "_early"}, {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    check({tag, "_valid"},  {31'd0, bus.out_valid},  32'd1);
    check({tag, "_data"},   bus.out_data,             v.data);
    check({tag, "_to_int"}, {31'd0, bus.out_to_int}, {31'd0, v.to_int});
    check({tag, "_nv"},     {31'd0, bus.out_nv},     {31'd0, v.nv});
    check({tag, "_rd"},     {27'd0, bus.out_rd},     {27'd0, rd});
  endtask

  task automatic drive_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                          input logic [4:0] rd);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_x     = x;
    bus.in_y     = y;
    bus.in_rd    = rd;
  endtask

  initial begin
    vecs[0]  = '{3'd1, 32'hBF800000, 32'h3F800000, 32'h00000001, 1'b1, 1'b0};
    vecs[1]  = '{3'd2, 32'h80000000, 32'h00000000, 32'h00000001, 1'b1, 1'b0};
    vecs[2]  = '{3'd0, 32'h80000000, 32'h00000000, 32'h00000001, 1'b1, 1'b0};
    vecs[3]  = '{3'd1, 32'h80000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0};
    vecs[4]  = '{3'd3, 32'h80000000, 32'h00000000, 32'h80000000, 1'b0, 1'b0};
    vecs[5]  = '{3'd4, 32'h80000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0};
    vecs[6]  = '{3'd3, 32'h00000000, 32'h80000000, 32'h80000000, 1'b0, 1'b0};
    vecs[7]  = '{3'd4, 32'h00000000, 32'h80000000, 32'h00000000, 1'b0, 1'b0};
    vecs[8]  = '{3'd1, 32'h7FC00000, 32'h3F800000, 32'h00000000, 1'b1, 1'b1};
    vecs[9]  = '{3'd0, 32'h7F800001, 32'h3F800000, 32'h00000000, 1'b1, 1'b1};
    vecs[10] = '{3'd4, 32'h7FC00000, 32'h40000000, 32'h40000000, 1'b0, 1'b0};
    vecs[11] = '{3'd3, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 1'b0, 1'b0};
    vecs[12] = '{3'd0, 32'h7FC00000, 32'h7FC00000, 32'h00000000, 1'b1, 1'b0};
    vecs[13] = '{3'd1, 32'hC0000000, 32'hBF800000, 32'h00000001, 1'b1, 1'b0};
    vecs[14] = '{3'd2, 32'h3F800000, 32'h3F800000, 32'h00000001, 1'b1, 1'b0};
    vecs[15] = '{3'd3, 32'h3F800000, 32'hC0000000, 32'hC0000000, 1'b0, 1'b0};
    vecs[16] = '{3'd4, 32'h3F800000, 32'hC0000000, 32'h3F800000, 1'b0, 1'b0};
    vecs[17] = '{3'd5, 32'h3F800000, 32'h00000000, 32'h00000000, 1'b1, 1'b0};
    vecs[18] = '{3'd3, 32'h7F800001, 32'h3F800000, 32'h3F800000, 1'b0, 1'b1};
    vecs[19] = '{3'd1, 32'h3F800000, 32'h40000000, 32'h00000001, 1'b1, 1'b0};
    vecs[20] = '{3'd2, 32'h40000000, 32'h3F800000, 32'h00000000, 1'b1, 1'b0};
    vecs[21] = '{3'd0, 32'hFF800000, 32'hFF800000, 32'h00000001, 1'b1, 1'b0};

    rstn          = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = 3'd0;
    bus.in_x      = 32'd0;
    bus.in_y      = 32'd0;
    bus.in_rd     = 5'd0;
    bus.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_out_valid",  {31'd0, bus.out_valid},  32'd0);
    check("rst_out_data",   bus.out_data,             32'd0);
    check("rst_out_rd",     {27'd0, bus.out_rd},     32'd0);
    check("rst_out_to_int", {31'd0, bus.out_to_int}, 32'd0);
    check("rst_out_nv",     {31'd0, bus.out_nv},     32'd0);
    rstn = 1'b1;
    #1;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    for (int i = 0; i < NVEC; i++) begin
      run_vector(vecs[i], 5'(i), $sformatf("v%0d", i));
    end

    // Back-to-back four ops with writeback stalled after the first result.
    begin
      logic [2:0]  b_op [4];
      logic [31:0] b_x [4];
      logic [31:0] b_y [4];
      logic [31:0] b_exp [4];
      int sent = 0;
      int got = 0;
      int stall = 0;
      bit seen = 0;
      bit ir_checked = 0;
      b_op[0] = 3'd1; b_x[0] = 32'hBF800000; b_y[0] = 32'h3F800000; b_exp[0] = 32'h00000001;
      b_op[1] = 3'd4; b_x[1] = 32'h3F800000; b_y[1] = 32'h40000000; b_exp[1] = 32'h40000000;
      b_op[2] = 3'd0; b_x[2] = 32'h3F800000; b_y[2] = 32'h3F800000; b_exp[2] = 32'h00000001;
      b_op[3] = 3'd3; b_x[3] = 32'h40400000; b_y[3] = 32'hC0400000; b_exp[3] = 32'hC0400000;
      for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
        @(negedge clk);
        if (bus.out_valid) seen = 1;
        if (seen && stall < 3) begin
          bus.out_ready = 1'b0;
          stall++;
        end else begin
          bus.out_ready = seen;
        end
        if (sent < 4) drive_op(b_op[sent], b_x[sent], b_y[sent], 5'(20 + sent));
        else bus.in_valid = 1'b0;
        #1;
        if (sent == 2 && !ir_checked) begin
          check("b2b_in_ready_drop", {31'd0, bus.in_ready}, 32'd0);
          ir_checked = 1;
        end
        if (bus.in_valid && bus.in_ready) sent++;
        if (bus.out_valid && bus.out_ready) begin
          check($sformatf("b2b_data%0d", got), bus.out_data, b_exp[got]);
          check($sformatf("b2b_rd%0d", got), {27'd0, bus.out_rd}, 32'(20 + got));
          got++;
        end
      end
      check("b2b_count", 32'(got), 32'd4);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check("b2b_no_dup", {31'd0, bus.out_valid}, 32'd0);
      end
    end

    // Flush with S2 stalled and S1 occupied; the op offered during flush is dropped.
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive_op(3'd1, 32'hBF800000, 32'h3F800000, 5'd10);
    @(negedge clk);
    drive_op(3'd4, 32'h3F800000, 32'h40000000, 5'd11);
    @(negedge clk);
    check("fl_pre_valid", {31'd0, bus.out_valid}, 32'd1);
    flush = 1'b1;
    drive_op(3'd0, 32'h3F800000, 32'h3F800000, 5'd12);
    #1;
    check("fl_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("fl_s2_clear", {31'd0, bus.out_valid}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("fl_s1_clear", {31'd0, bus.out_valid}, 32'd0);
    end
    run_vector(vecs[16], 5'd13, "fl_next");

    // Async reset while a result is stalled at the output.
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive_op(3'd1, 32'hBF800000, 32'h3F800000, 5'd7);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("ar_pre_valid", {31'd0, bus.out_valid}, 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    check("ar_out_valid",  {31'd0, bus.out_valid},  32'd0);
    check("ar_out_data",   bus.out_data,             32'd0);
    check("ar_out_rd",     {27'd0, bus.out_rd},     32'd0);
    check("ar_out_to_int", {31'd0, bus.out_to_int}, 32'd0);
    check("ar_out_nv",     {31'd0, bus.out_nv},     32'd0);
    @(negedge clk);
    rstn = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check("ar_in_ready", {31'd0, bus.in_ready}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("ar_no_output", {31'd0, bus.out_valid}, 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
